// File: rtl/i2c_rx_if.sv
// Bus-side bundle of the I2C receive deserialiser: raw SCL/SDA, flow control
// and the word/status outputs.
interface i2c_rx_if #(
    parameter int DATA_W = 8
);
    logic              scl_i;
    logic              sda_i;
    logic              enable_desp;
    logic              ready_i;
    logic              ovr_clr_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              start_o;
    logic              stop_o;
    logic              overrun_o;
    logic              busy_o;

    modport master (
        output scl_i, sda_i, enable_desp, ready_i, ovr_clr_i,
        input  data_o, valid_o, start_o, stop_o, overrun_o, busy_o
    );

    modport slave (
        input  scl_i, sda_i, enable_desp, ready_i, ovr_clr_i,
        output data_o, valid_o, start_o, stop_o, overrun_o, busy_o
    );
endinterface

// File: rtl/i2c_rx_deserializer.sv
// Passive I2C receiver: synchronises SCL/SDA, detects START/STOP, shifts in
// DATA_W-bit words (skipping the ACK slot) and hands them to a valid/ready register.
module i2c_rx_deserializer #(
    parameter int DATA_W      = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    i2c_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   start_q, start_d;
    logic                   stop_q, stop_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;

    logic                   scl_s, sda_s;
    logic                   scl_rise, start_det, stop_det;
    logic                   word_offer;
    logic [DATA_W-1:0]      shifted;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Only the last synchroniser stage and its history flop feed detection.
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign start_det = scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[DATA_W-2:0], sda_s};
        end else begin
            shifted = {sda_s, shift_q[DATA_W-1:1]};
        end
    end

    // Bus conditions outrank an SCL rise seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_offer = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
        end else if (start_det) begin
            state_d = RECV;
            cnt_d   = '0;
            shift_d = '0;
        end else if (scl_rise) begin
            unique case (state_q)
                RECV: begin
                    if (bus.enable_desp) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            word_offer = 1'b1;
                            state_d    = ACK;
                            cnt_d      = '0;
                            shift_d    = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            shift_d = shifted;
                        end
                    end
                end
                ACK:     state_d = RECV;
                default: state_d = state_q;
            endcase
        end
    end

    // Output register: a pending word is never overwritten unless accepted.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (bus.ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        if (word_offer) begin
            if (!valid_q || bus.ready_i) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
        start_d = start_det;
        stop_d  = stop_det;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            cnt_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.start_o   = start_q;
    assign bus.stop_o    = stop_q;
    assign bus.overrun_o = ovr_q;
    assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// Directed bench: one MSB-first and one LSB-first receiver share a bus driven
// by bit-level tasks; results are compared against hand-computed words.
module tb_i2c_rx_deserializer;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic scl, sda, enable, ready, ovr_clr;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   stop_cnt = 0;
    int   s0, p0;

    always #5 clk = ~clk;

    i2c_rx_if #(.DATA_W(8)) bus_m ();
    i2c_rx_if #(.DATA_W(8)) bus_l ();

    assign bus_m.scl_i       = scl;
    assign bus_m.sda_i       = sda;
    assign bus_m.enable_desp = enable;
    assign bus_m.ready_i     = ready;
    assign bus_m.ovr_clr_i   = ovr_clr;
    assign bus_l.scl_i       = scl;
    assign bus_l.sda_i       = sda;
    assign bus_l.enable_desp = enable;
    assign bus_l.ready_i     = ready;
    assign bus_l.ovr_clr_i   = ovr_clr;

    i2c_rx_deserializer #(.DATA_W(8), .MSB_FIRST(1), .SYNC_STAGES(S)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m)
    );
    i2c_rx_deserializer #(.DATA_W(8), .MSB_FIRST(0), .SYNC_STAGES(S)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l)
    );

    always @(posedge clk) begin
        if (bus_m.start_o) start_cnt <= start_cnt + 1;
        if (bus_m.stop_o)  stop_cnt  <= stop_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain bit; 1: check valid_o latency; 2: pulse ready_i in the completion cycle
    task automatic send_bit(input logic b, input int mode);
        @(negedge clk) sda = b;
        repeat (3) @(negedge clk);
        scl = 1'b1;
        if (mode == 1) begin
            repeat (S) @(posedge clk);
            #1 check_eq("lat_before", 32'(bus_m.valid_o), 32'd0);
            @(posedge clk);
            #1 check_eq("lat_at", 32'(bus_m.valid_o), 32'd1);
        end else if (mode == 2) begin
            repeat (S) @(posedge clk);
            @(negedge clk) ready = 1'b1;
            @(negedge clk) ready = 1'b0;
        end
        repeat (5) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int last_mode);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], (i == 0) ? last_mode : 0);
        end
    endtask

    task automatic bus_start();
        @(negedge clk) sda = 1'b1;
        repeat (2) @(negedge clk);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        sda = 1'b0;
        repeat (6) @(negedge clk);
        scl = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_stop();
        @(negedge clk) sda = 1'b0;
        repeat (2) @(negedge clk);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        sda = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check_eq("consume_valid", 32'(bus_m.valid_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        enable = 1'b1; ready = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(bus_m.data_o), 32'd0);
        check_eq("rst_valid", 32'(bus_m.valid_o), 32'd0);
        check_eq("rst_start", 32'(bus_m.start_o), 32'd0);
        check_eq("rst_stop", 32'(bus_m.stop_o), 32'd0);
        check_eq("rst_ovr", 32'(bus_m.overrun_o), 32'd0);
        check_eq("rst_busy", 32'(bus_m.busy_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("txn reset done");

        // 0xA5 with latency check on the last bit
        s0 = start_cnt; p0 = stop_cnt;
        bus_start();
        check_eq("a5_busy_in", 32'(bus_m.busy_o), 32'd1);
        send_byte(8'hA5, 1);
        check_eq("a5_data_m", 32'(bus_m.data_o), 32'hA5);
        check_eq("a5_data_l", 32'(bus_l.data_o), 32'hA5);
        send_bit(1'b0, 0);
        bus_stop();
        check_eq("a5_busy_out", 32'(bus_m.busy_o), 32'd0);
        check_eq("a5_starts", 32'(start_cnt - s0), 32'd1);
        check_eq("a5_stops", 32'(stop_cnt - p0), 32'd1);
        check_eq("a5_valid", 32'(bus_m.valid_o), 32'd1);
        consume();
        $display("txn byte 0xA5 data_m=0x%0h", bus_m.data_o);

        // 1100_0000: LSB-first receiver sees 0x03
        bus_start();
        send_byte(8'hC0, 0);
        send_bit(1'b0, 0);
        bus_stop();
        check_eq("c0_data_m", 32'(bus_m.data_o), 32'hC0);
        check_eq("c0_data_l", 32'(bus_l.data_o), 32'h03);
        consume();
        $display("txn byte 0xC0 data_l=0x%0h", bus_l.data_o);

        // overrun: 0x12 then 0x34 with nothing accepted
        bus_start();
        send_byte(8'h12, 0);
        send_bit(1'b0, 0);
        send_byte(8'h34, 0);
        send_bit(1'b0, 0);
        bus_stop();
        check_eq("ovr_data_m", 32'(bus_m.data_o), 32'h12);
        check_eq("ovr_data_l", 32'(bus_l.data_o), 32'h48);
        check_eq("ovr_flag", 32'(bus_m.overrun_o), 32'd1);
        check_eq("ovr_valid", 32'(bus_m.valid_o), 32'd1);
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        check_eq("ovr_clr", 32'(bus_m.overrun_o), 32'd0);
        consume();
        $display("txn overrun 0x12/0x34");

        // back-to-back: ready_i exactly when the second word completes
        bus_start();
        send_byte(8'h12, 0);
        send_bit(1'b0, 0);
        send_byte(8'h34, 2);
        check_eq("b2b_data", 32'(bus_m.data_o), 32'h34);
        check_eq("b2b_valid", 32'(bus_m.valid_o), 32'd1);
        check_eq("b2b_ovr", 32'(bus_m.overrun_o), 32'd0);
        send_bit(1'b0, 0);
        bus_stop();
        consume();
        $display("txn back-to-back 0x34");

        // repeated START after 3 bits
        s0 = start_cnt;
        bus_start();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        bus_start();
        send_byte(8'hFF, 0);
        send_bit(1'b1, 0);
        bus_stop();
        check_eq("rs_data_m", 32'(bus_m.data_o), 32'hFF);
        check_eq("rs_data_l", 32'(bus_l.data_o), 32'hFF);
        check_eq("rs_starts", 32'(start_cnt - s0), 32'd2);
        consume();
        $display("txn repeated start 0xFF");

        // enable_desp low for two rises mid-word
        bus_start();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk) enable = 1'b0;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(negedge clk) enable = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check_eq("en_data_m", 32'(bus_m.data_o), 32'h5A);
        check_eq("en_data_l", 32'(bus_l.data_o), 32'h5A);
        send_bit(1'b0, 0);
        $display("txn enable gap 0x5A");

        // reset mid-word, then stray bits must be ignored until a new START
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_eq("mrst_data", 32'(bus_m.data_o), 32'd0);
        check_eq("mrst_valid", 32'(bus_m.valid_o), 32'd0);
        check_eq("mrst_busy", 32'(bus_m.busy_o), 32'd0);
        check_eq("mrst_ovr", 32'(bus_m.overrun_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h3C, 0);
        send_bit(1'b0, 0);
        send_byte(8'hF0, 0);
        send_bit(1'b0, 0);
        check_eq("mrst_no_valid", 32'(bus_m.valid_o), 32'd0);
        check_eq("mrst_idle", 32'(bus_m.busy_o), 32'd0);
        bus_start();
        send_byte(8'h3C, 0);
        send_bit(1'b0, 0);
        bus_stop();
        check_eq("post_rst_data", 32'(bus_m.data_o), 32'h3C);
        check_eq("post_rst_valid", 32'(bus_m.valid_o), 32'd1);
        $display("txn reset mid-word then 0x3C");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
